ps2_key_event: RTL and testbench
================================

Name: ps2_key_event

Overview:
- Upstream of the VGA game controller. Converts the raw PS/2 scan-code byte stream into one-cycle key events: key_in/key_en.
- Decodes the E0 (extended) and F0 (break) prefixes and suppresses typematic re-makes.
- Tracks which arrow keys are held.
- Runs in the VGA clock domain. The PS/2 byte receiver ahead of it is already synchronised to vga_clk.

Parameters:
- TIMEOUT_CYCLES, 2500000: cycles a prefix state waits for the next byte before abandoning the sequence (100 ms at 25 MHz).
- REPEAT_DELAY, 6250000: cycles from an arrow make to the first auto-repeat (used only with the optional feature).
- REPEAT_PERIOD, 2500000: cycles between subsequent auto-repeats (used only with the optional feature).
- CNT_W, 24: width of the timeout and repeat counters. Every count parameter must be below 2^CNT_W.

Ports:
- vga_clk, input, 1: the only clock.
- reset, input, 1: synchronous, active-high reset.
- ps2_data, input, 8: received scan-code byte.
- ps2_valid, input, 1: one-cycle strobe, ps2_data valid. May be asserted on back-to-back cycles.
- key_in, output, 8: scan code of the event, with prefixes stripped (e.g. 8'h6b left, 8'h74 right, 8'h75 up, 8'h72 down).
- key_en, output, 1: one-cycle event strobe.
- key_ext, output, 1: the event carried the E0 prefix. Valid with key_en.
- key_rpt, output, 1: the event is an auto-repeat. Valid with key_en. Always 0 without the optional feature.
- held, output, 4: arrow keys currently held, as {down, up, right, left}.

Behaviour:
- Reset (synchronous, any state):
  - State goes to IDLE.
  - key_in=0, key_en=0, key_ext=0, key_rpt=0, held=0.
  - Counters clear.
  - A sequence in progress is discarded and produces no event.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- Transitions. These are evaluated only on cycles with ps2_valid=1.
  - IDLE:
    - E0 goes to EXT.
    - F0 goes to BRK.
    - Any other byte is a make with ext=0; stay in IDLE.
  - EXT:
    - F0 goes to EXT_BRK.
    - Any other byte is a make with ext=1; go to IDLE.
  - BRK: any byte is a break with ext=0; go to IDLE.
  - EXT_BRK: any byte is a break with ext=1; go to IDLE.
- Dropped bytes:
  - Bytes 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1 are dropped in every state and force IDLE.
  - A dropped byte never produces an event.
  - A dropped byte received as the first byte of a make is also ignored.
- Make event:
  - If the code is an arrow (ext=1 and code in {6b, 74, 75, 72}) and its held bit is already 1, it is a typematic re-make and is suppressed: no key_en.
  - Otherwise, on the next cycle: key_en=1, key_in=code, key_ext=ext, key_rpt=0.
  - For an arrow, the held bit is set in the same update.
- Break event:
  - Never raises key_en.
  - For an extended arrow, the held bit is cleared.
  - Break of a key that is not held has no effect.
- Latency: key_en is asserted exactly one cycle after the ps2_valid of the final byte of the sequence.
- key_en outputs:
  - key_en is high for one cycle only.
  - key_in, key_ext and key_rpt hold their last values when key_en=0.
- Timeout:
  - The timeout counter starts on entry to EXT, BRK or EXT_BRK and reloads on each accepted byte.
  - If it reaches TIMEOUT_CYCLES with no ps2_valid, the state returns to IDLE with no event.
  - A ps2_valid on the same cycle as the timeout expiry wins: the byte is processed in the current state.
- Non-arrow keys produce make events only. They have no held tracking.

Optional Feature:
- Macro: PS2_AUTO_REPEAT_EN.
- With the macro defined:
  - The last arrow made becomes the repeat key. Its repeat counter loads REPEAT_DELAY.
  - Each time the counter expires, the block emits key_en=1, key_in=that code, key_ext=1, key_rpt=1. The counter then reloads REPEAT_PERIOD.
  - Repeats stop when that key is released, even if other arrows remain held.
  - A new arrow make takes over the repeat key and restarts REPEAT_DELAY.
  - If a real event and a repeat expiry fall on the same cycle, the real event is output and the repeat is dropped. The counter reloads REPEAT_PERIOD.
- Without the macro: no repeat counter is present, key_rpt is tied to 0, and only real make events are produced.

Test Plan:
1. Reset, then bytes E0, 6B on consecutive cycles -> one cycle after 6B: key_en=1, key_in=8'h6b, key_ext=1, held=4'b0001.
2. With left held, send E0, 6B again -> no key_en, held=4'b0001. Then send E0, F0, 6B -> no key_en, held=4'b0000.
3. Send 1C (plain 'A') -> key_en=1, key_in=8'h1c, key_ext=0, held unchanged. Then send F0, 1C -> no event.
4. With TIMEOUT_CYCLES=8: send E0 and wait 8 idle cycles, then send 74 -> key_en=1, key_in=8'h74, key_ext=0 (E0 was abandoned).
5. Send E0, then assert reset, then send 74 -> no event during reset; afterwards key_in=8'h74, key_ext=0, held=0.
6. PS2_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4: make E0 74 -> real event, then repeats with key_rpt=1 at +10, +14, +18 cycles. Send E0 F0 74 -> repeats stop, held=0.

Source files
------------

// File: rtl/ps2_key_event_if.sv
// Scan-code byte input and decoded key-event output bundle for ps2_key_event.
interface ps2_key_event_if;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic [7:0] key_in;
    logic       key_en;
    logic       key_ext;
    logic       key_rpt;
    logic [3:0] held;

    modport master (
        output ps2_data, ps2_valid,
        input  key_in, key_en, key_ext, key_rpt, held
    );

    modport slave (
        input  ps2_data, ps2_valid,
        output key_in, key_en, key_ext, key_rpt, held
    );
endinterface

// File: rtl/ps2_key_event.sv
// PS/2 scan codes -> one-cycle key events, E0/F0 decode, arrow held map; PS2_AUTO_REPEAT_EN adds arrow auto-repeat.
// Latency: key_en one cycle after the ps2_valid of the final byte of a sequence.
// Backpressure: none, a byte is accepted on every ps2_valid cycle including back-to-back.
module ps2_key_event #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned REPEAT_DELAY   = 6250000,
    parameter int unsigned REPEAT_PERIOD  = 2500000,
    parameter int unsigned CNT_W          = 24
) (
    input logic            vga_clk,
    input logic            reset,
    ps2_key_event_if.slave bus
);
    localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;
    if (TIMEOUT_CYCLES >= CNT_LIM || REPEAT_DELAY >= CNT_LIM || REPEAT_PERIOD >= CNT_LIM) begin : g_cnt_range
        $error("ps2_key_event: count parameter does not fit in CNT_W bits");
    end

    localparam logic [7:0]       B_E0     = 8'hE0;
    localparam logic [7:0]       B_F0     = 8'hF0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;

    logic       drop;
    logic       fin;
    logic       seq_ext;
    logic       seq_brk;
    logic [3:0] arrow_bit;
    logic [3:0] ext_arrow;
    logic       make;
    logic       brk;
    logic       real_make;

    always_comb begin
        drop = 1'b0;
        case (bus.ps2_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: drop = 1'b1;
            default: drop = 1'b0;
        endcase

        arrow_bit = 4'b0000;
        case (bus.ps2_data)
            8'h6B: arrow_bit = 4'b0001;
            8'h74: arrow_bit = 4'b0010;
            8'h75: arrow_bit = 4'b0100;
            8'h72: arrow_bit = 4'b1000;
            default: arrow_bit = 4'b0000;
        endcase

        // fin marks the byte that completes a make or break sequence
        case (state)
            IDLE:    fin = (bus.ps2_data != B_E0) && (bus.ps2_data != B_F0);
            EXT:     fin = (bus.ps2_data != B_F0);
            default: fin = 1'b1;
        endcase
        fin = fin && bus.ps2_valid && !drop;

        seq_ext   = (state == EXT) || (state == EXT_BRK);
        seq_brk   = (state == BRK) || (state == EXT_BRK);
        ext_arrow = seq_ext ? arrow_bit : 4'b0000;
        make      = fin && !seq_brk;
        brk       = fin && seq_brk;
        real_make = make && ((ext_arrow & bus.held) == 4'b0000);
    end

`ifdef PS2_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_act;
    logic [7:0]       rpt_code;
    logic             rpt_new;
    logic             rpt_stop;
    logic             rpt_fire;

    always_comb begin
        rpt_new  = real_make && (ext_arrow != 4'b0000);
        rpt_stop = brk && rpt_act && (ext_arrow != 4'b0000) && (bus.ps2_data == rpt_code);
        rpt_fire = rpt_act && !rpt_stop && (rpt_cnt == CNT_W'(1));
    end
`else
    assign bus.key_rpt = 1'b0;
`endif

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            bus.key_in  <= 8'h00;
            bus.key_en  <= 1'b0;
            bus.key_ext <= 1'b0;
            bus.held    <= 4'b0000;
`ifdef PS2_AUTO_REPEAT_EN
            bus.key_rpt <= 1'b0;
            rpt_cnt     <= '0;
            rpt_act     <= 1'b0;
            rpt_code    <= 8'h00;
`endif
        end else begin
            bus.key_en <= 1'b0;

            if (bus.ps2_valid) begin
                tmo_cnt <= '0;
                if (drop) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE: begin
                            if (bus.ps2_data == B_E0)      state <= EXT;
                            else if (bus.ps2_data == B_F0) state <= BRK;
                        end
                        EXT:     state <= (bus.ps2_data == B_F0) ? EXT_BRK : IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end

            if (real_make) begin
                bus.key_en  <= 1'b1;
                bus.key_in  <= bus.ps2_data;
                bus.key_ext <= seq_ext;
                bus.held    <= bus.held | ext_arrow;
`ifdef PS2_AUTO_REPEAT_EN
                bus.key_rpt <= 1'b0;
            end else if (rpt_fire) begin
                bus.key_en  <= 1'b1;
                bus.key_in  <= rpt_code;
                bus.key_ext <= 1'b1;
                bus.key_rpt <= 1'b1;
`endif
            end

            if (brk) bus.held <= bus.held & ~ext_arrow;

`ifdef PS2_AUTO_REPEAT_EN
            // a real event coinciding with expiry swallows that repeat but keeps the cadence
            if (rpt_new) begin
                rpt_act  <= 1'b1;
                rpt_code <= bus.ps2_data;
                rpt_cnt  <= RPT_DLY;
            end else if (rpt_stop) begin
                rpt_act <= 1'b0;
            end else if (rpt_act) begin
                rpt_cnt <= (rpt_cnt == CNT_W'(1)) ? RPT_PER : rpt_cnt - CNT_W'(1);
            end
`endif
        end
    end
endmodule

// File: tb/tb_ps2_key_event.sv
// Directed test-plan steps followed by random byte traffic, all checked against a queue-free event model.
module tb_ps2_key_event;
    localparam int TMO = 8;
    localparam int RD  = 10;
    localparam int RP  = 4;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    ps2_key_event_if bus ();

    ps2_key_event #(
        .TIMEOUT_CYCLES(TMO),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .CNT_W         (24)
    ) dut (
        .vga_clk(vga_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 vga_clk = ~vga_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model: prefix flags, idle gap, held map, last outputs, next repeat time
    bit         m_ext, m_brk;
    int         gap;
    logic [3:0] m_held;
    logic [7:0] m_key;
    logic       m_en, m_xt, m_rpt;
    bit         r_on;
    logic [7:0] r_code;
    int         r_due;

    function automatic int arrow_idx(input logic [7:0] c);
        case (c)
            8'h6B:   return 0;
            8'h74:   return 1;
            8'h75:   return 2;
            8'h72:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit v, input logic [7:0] d);
        bit real_ev;
        int ai;
        m_en    = 1'b0;
        real_ev = 1'b0;
        if (rst) begin
            m_ext = 0; m_brk = 0; gap = 0;
            m_held = 4'b0; m_key = 8'h00; m_xt = 1'b0; m_rpt = 1'b0;
            r_on = 0; r_code = 8'h00; r_due = 0;
            return;
        end
        if (v) begin
            if (d inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1}) begin
                m_ext = 0; m_brk = 0;
            end else if (!m_ext && !m_brk && d == 8'hE0) begin
                m_ext = 1; gap = 0;
            end else if (!m_brk && d == 8'hF0) begin
                m_brk = 1; gap = 0;
            end else begin
                ai = m_ext ? arrow_idx(d) : -1;
                if (m_brk) begin
                    if (ai >= 0) begin
                        m_held[ai] = 1'b0;
                        if (r_on && r_code == d) r_on = 0;
                    end
                end else if (!(ai >= 0 && m_held[ai])) begin
                    real_ev = 1'b1;
                    m_en = 1'b1; m_key = d; m_xt = m_ext; m_rpt = 1'b0;
                    if (ai >= 0) begin
                        m_held[ai] = 1'b1;
`ifdef PS2_AUTO_REPEAT_EN
                        r_on = 1; r_code = d; r_due = cyc + RD;
`endif
                    end
                end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            gap++;
            if (gap == TMO) begin
                m_ext = 0; m_brk = 0;
            end
        end
        if (r_on && cyc == r_due) begin
            r_due = r_due + RP;
            if (!real_ev) begin
                m_en = 1'b1; m_key = r_code; m_xt = 1'b1; m_rpt = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [7:0] d);
        @(negedge vga_clk);
        reset         = rst;
        bus.ps2_valid = v;
        bus.ps2_data  = d;
        @(posedge vga_clk);
        cyc++;
        model_edge(rst, v, d);
        #1;
        chk("key_en",  {7'b0, bus.key_en},  {7'b0, m_en});
        chk("key_in",  bus.key_in,          m_key);
        chk("key_ext", {7'b0, bus.key_ext}, {7'b0, m_xt});
        chk("key_rpt", {7'b0, bus.key_rpt}, {7'b0, m_rpt});
        chk("held",    {4'b0, bus.held},    {4'b0, m_held});
    endtask

    task automatic byte_in(input logic [7:0] d);
        step(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    logic [7:0] pool [16] = '{8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h6B, 8'h74, 8'h75,
                              8'h72, 8'h1C, 8'h29, 8'h5A, 8'hAA, 8'hFA, 8'h00, 8'hE1};

    initial begin
        bus.ps2_valid = 1'b0;
        bus.ps2_data  = 8'h00;

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h1C);
        chk("rst_en",   {7'b0, bus.key_en}, 8'h00);
        chk("rst_in",   bus.key_in,         8'h00);
        chk("rst_held", {4'b0, bus.held},   8'h00);

        byte_in(8'hE0); byte_in(8'h6B);
        chk("p1_en",   {7'b0, bus.key_en},  8'h01);
        chk("p1_in",   bus.key_in,          8'h6B);
        chk("p1_ext",  {7'b0, bus.key_ext}, 8'h01);
        chk("p1_held", {4'b0, bus.held},    8'h01);

        byte_in(8'hE0); byte_in(8'h6B);
        chk("p2_remake_en",   {7'b0, bus.key_en}, 8'h00);
        chk("p2_remake_held", {4'b0, bus.held},   8'h01);
        byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h6B);
        chk("p2_brk_en",   {7'b0, bus.key_en}, 8'h00);
        chk("p2_brk_held", {4'b0, bus.held},   8'h00);

        byte_in(8'h1C);
        chk("p3_en",  {7'b0, bus.key_en},  8'h01);
        chk("p3_in",  bus.key_in,          8'h1C);
        chk("p3_ext", {7'b0, bus.key_ext}, 8'h00);
        byte_in(8'hF0); byte_in(8'h1C);
        chk("p3_brk_en", {7'b0, bus.key_en}, 8'h00);

        byte_in(8'hE0); idle(TMO); byte_in(8'h74);
        chk("p4_en",   {7'b0, bus.key_en},  8'h01);
        chk("p4_in",   bus.key_in,          8'h74);
        chk("p4_ext",  {7'b0, bus.key_ext}, 8'h00);
        chk("p4_held", {4'b0, bus.held},    8'h00);

        byte_in(8'hE0); idle(TMO - 1); byte_in(8'h74);
        chk("tmo_edge_ext",  {7'b0, bus.key_ext}, 8'h01);
        chk("tmo_edge_held", {4'b0, bus.held},    8'h02);
        byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h74);
        chk("tmo_edge_brk", {4'b0, bus.held}, 8'h00);

        byte_in(8'hE0); byte_in(8'hAA); byte_in(8'h6B);
        chk("drop_ext",  {7'b0, bus.key_ext}, 8'h00);
        chk("drop_held", {4'b0, bus.held},    8'h00);
        byte_in(8'hFA);
        chk("drop_en", {7'b0, bus.key_en}, 8'h00);

        byte_in(8'hE0); step(1'b1, 1'b0, 8'h00);
        chk("p5_rst_en", {7'b0, bus.key_en}, 8'h00);
        byte_in(8'h74);
        chk("p5_in",   bus.key_in,          8'h74);
        chk("p5_ext",  {7'b0, bus.key_ext}, 8'h00);
        chk("p5_held", {4'b0, bus.held},    8'h00);

`ifdef PS2_AUTO_REPEAT_EN
        byte_in(8'hE0); byte_in(8'h74);
        chk("p6_real_rpt", {7'b0, bus.key_rpt}, 8'h00);
        for (int i = 1; i < 20; i++) begin
            idle(1);
            if (i == 10 || i == 14 || i == 18) begin
                chk("p6_rpt_en",  {7'b0, bus.key_en},  8'h01);
                chk("p6_rpt_flag", {7'b0, bus.key_rpt}, 8'h01);
                chk("p6_rpt_in",  bus.key_in,          8'h74);
            end else begin
                chk("p6_gap_en", {7'b0, bus.key_en}, 8'h00);
            end
        end
        byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h74);
        for (int i = 0; i < 12; i++) begin
            idle(1);
            chk("p6_stop_en", {7'b0, bus.key_en}, 8'h00);
        end
        chk("p6_held", {4'b0, bus.held}, 8'h00);
`endif

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       step(1'b1, 1'b0, 8'h00);
            else if (r < 5)  idle($urandom_range(5, 12));
            else if (r < 40) idle(1);
            else             byte_in(pool[$urandom_range(0, 15)]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
